crossbar_route_scheduler: RTL and testbench
===========================================

// Module: crossbar_route_scheduler
// PURPOSE
//  Upstream control stage of the NxN crossbar. Collects per-input route requests and proposes one
//  route set (route/output_enable) to the collision monitor, which sits directly downstream.
//  Reads back collision_error and drops lowest-priority requesters until the set is clean.
//  Then issues the set to the barrel-shifter datapath via a valid/ready handshake. Priority is round-robin.
// PARAMETERS
//  N           8              number of ports, N = 2^k, N >= 2
//  ROUTE_BITS  $clog2(N)      localparam, destination index width
// PORTS
//  clk              in   1               single clock, all state on rising edge
//  rst              in   1               synchronous, active-high reset
//  in_valid         in   [N]             input i requests a path this round
//  in_dest          in   [ROUTE_BITS][N] destination port of input i
//  in_ready         out  [N]             1-cycle grant pulse, input i's request consumed
//  route            out  [ROUTE_BITS][N] registered proposed destination per input (to monitor/datapath)
//  output_enable    out  [N]             registered, input i is part of the proposed set
//  collision_error  in   1               from collision monitor, combinational on route/output_enable
//  cfg_valid        out  1               route set is final, datapath may load it
//  cfg_ready        in   1               datapath accepts the set
//  busy             out  1               state != IDLE
//  drop_cnt         out  [ROUTE_BITS]    requesters dropped in the current/last round (saturates at N-1)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, rr_ptr=0; route=0, output_enable=0, in_ready=0, cfg_valid=0,
//   busy=0, drop_cnt=0. Reset wins over every other event, including mid-EVAL/GRANT.
//  Priority: rr_ptr is the highest priority, then rr_ptr+1, and so on mod N. The lowest priority is (rr_ptr-1) mod N.
//  FSM:
//  IDLE:  if |in_valid: capture cand=in_valid, route[i]=in_dest[i], output_enable=cand, drop_cnt=0;
//         go to EVAL. Else hold; output_enable stays 0.
//  EVAL:  route/output_enable stable for the full cycle; sample collision_error at the end of the cycle.
//         If 0, go to GRANT and set cfg_valid=1.
//         If 1, clear the lowest-priority set bit of output_enable, increment drop_cnt, stay in EVAL.
//         A single enabled input never collides, so EVAL exits within popcount(cand) cycles.
//  GRANT: cfg_valid=1 and route/output_enable are held until cfg_ready=1.
//         On the cfg_ready edge: in_ready[i]=output_enable[i] & in_valid[i] for one cycle,
//         cfg_valid->0, output_enable->0, rr_ptr->(rr_ptr+1) mod N, go to IDLE.
//  Latency without collisions: request seen in IDLE at cycle t; EVAL at t+1; cfg_valid at t+2.
//   in_ready at t+3 if cfg_ready=1 at t+2.
//  Requesters must hold in_valid/in_dest until in_ready. A dropped request stays pending and
//   competes in the next round.
//  in_valid falling mid-round is a protocol violation: the captured set is still used, and in_ready
//   is suppressed for inputs whose in_valid=0.
//  A new request arriving during a round waits for IDLE.
//  route[i] for disabled inputs retains its captured value; consumers must qualify with output_enable.
//  rr_ptr wraps N-1 -> 0.
//  drop_cnt holds its value in GRANT and IDLE until the next capture.
// TESTING (N=4, collision monitor instantiated or modelled)
//  1 Reset with random inputs -> all outputs 0, busy=0, rr_ptr=0 for 2+ cycles.
//  2 in_valid=1111, dest={1,2,3,0}, cfg_ready=1 -> cfg_valid at t+2, in_ready=1111 at t+3 only,
//    drop_cnt=0, rr_ptr=1.
//  3 rr_ptr=0, in_valid=0011, dest0=2, dest1=2 -> one EVAL collision, output_enable=0001, drop_cnt=1.
//    Grant input 0; next round grants input 1 with rr_ptr=1.
//  4 cfg_ready=0 for 3 cycles in GRANT -> cfg_valid, route and output_enable stable; in_ready=0 until accept.
//  5 rst pulsed in EVAL with a collision pending -> next cycle IDLE, all outputs 0; prior requests re-captured.
//  6 rr_ptr=3, in_valid=1001, both dest=0 -> input 3 wins, input 0 dropped; rr_ptr wraps to 0.

Source files
------------

// File: rtl/crossbar_route_scheduler_if.sv
// Handshake and route bus between the crossbar requesters, the collision monitor
// and the datapath; the scheduler drives it through the master modport.
interface crossbar_route_scheduler_if #(
    parameter int N = 8
);
    localparam int ROUTE_BITS = $clog2(N);

    logic [N-1:0]                 in_valid;
    logic [N-1:0][ROUTE_BITS-1:0] in_dest;
    logic [N-1:0]                 in_ready;
    logic [N-1:0][ROUTE_BITS-1:0] route;
    logic [N-1:0]                 output_enable;
    logic                         collision_error;
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic                         busy;
    logic [ROUTE_BITS-1:0]        drop_cnt;

    modport master (
        input  in_valid, in_dest, collision_error, cfg_ready,
        output in_ready, route, output_enable, cfg_valid, busy, drop_cnt
    );

    modport slave (
        output in_valid, in_dest, collision_error, cfg_ready,
        input  in_ready, route, output_enable, cfg_valid, busy, drop_cnt
    );
endinterface

// File: rtl/crossbar_route_scheduler.sv
// Round-robin route scheduler: captures requests, sheds lowest-priority inputs while
// the collision monitor objects, then hands the clean set to the datapath.
module crossbar_route_scheduler #(
    parameter int N = 8
) (
    input logic                      clk,
    input logic                      rst,
    crossbar_route_scheduler_if.master bus
);
    localparam int RB = $clog2(N);
    localparam logic [RB-1:0] DROP_MAX = RB'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [RB-1:0]         r_rr_ptr,    w_rr_ptr_nxt;
    logic [N-1:0][RB-1:0]  r_route,     w_route_nxt;
    logic [N-1:0]          r_oe,        w_oe_nxt;
    logic [N-1:0]          r_in_ready,  w_in_ready_nxt;
    logic                  r_cfg_valid, w_cfg_valid_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic [RB-1:0]         r_drop_cnt,  w_drop_cnt_nxt;
    logic [RB-1:0]         w_low_idx;
    logic [RB-1:0]         w_scan_idx;

    // Last enabled input in priority order starting at rr_ptr is the next one to shed.
    always_comb begin
        w_low_idx  = '0;
        w_scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_scan_idx = r_rr_ptr + RB'(k);
            if (r_oe[w_scan_idx]) begin
                w_low_idx = w_scan_idx;
            end else begin
                w_low_idx = w_low_idx;
            end
        end
    end

    // Next-state and next-output logic of the round FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_route_nxt     = r_route;
        w_oe_nxt        = r_oe;
        w_in_ready_nxt  = '0;
        w_cfg_valid_nxt = r_cfg_valid;
        w_drop_cnt_nxt  = r_drop_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|bus.in_valid) begin
                    w_route_nxt    = bus.in_dest;
                    w_oe_nxt       = bus.in_valid;
                    w_drop_cnt_nxt = '0;
                    w_state_nxt    = ST_EVAL;
                end else begin
                    w_oe_nxt = '0;
                end
            end
            ST_EVAL: begin
                // An empty set cannot collide, so it is treated as clean.
                if (bus.collision_error && (|r_oe)) begin
                    w_oe_nxt[w_low_idx] = 1'b0;
                    w_drop_cnt_nxt = (r_drop_cnt == DROP_MAX) ? r_drop_cnt
                                                              : r_drop_cnt + RB'(1);
                end else begin
                    w_cfg_valid_nxt = 1'b1;
                    w_state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus.cfg_ready) begin
                    w_in_ready_nxt  = r_oe & bus.in_valid;
                    w_cfg_valid_nxt = 1'b0;
                    w_oe_nxt        = '0;
                    w_rr_ptr_nxt    = r_rr_ptr + RB'(1);
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_oe_nxt        = '0;
                w_cfg_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_route     <= '0;
            r_oe        <= '0;
            r_in_ready  <= '0;
            r_cfg_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_route     <= w_route_nxt;
            r_oe        <= w_oe_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_cfg_valid <= w_cfg_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_drop_cnt  <= w_drop_cnt_nxt;
        end
    end

    assign bus.route         = r_route;
    assign bus.output_enable = r_oe;
    assign bus.in_ready      = r_in_ready;
    assign bus.cfg_valid     = r_cfg_valid;
    assign bus.busy          = r_busy;
    assign bus.drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_crossbar_route_scheduler.sv
// Bench for crossbar_route_scheduler (N=4): table of directed rounds, hand-written
// reset/stall/protocol sequences, then random rounds against a priority-prefix model.
module tb_crossbar_route_scheduler;
    localparam int N = 4;

    typedef logic [N-1:0][1:0] dest_t;

    typedef struct {
        logic [N-1:0] v;
        dest_t        d;
        int           delay;
        logic [N-1:0] exp_oe;
        int           exp_drop;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   m_rr;
    vec_t tbl[7];

    crossbar_route_scheduler_if #(.N(N)) bus ();

    crossbar_route_scheduler #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collision monitor: two enabled inputs aimed at the same output.
    always_comb begin
        bus.collision_error = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (bus.output_enable[i] && bus.output_enable[j] &&
                    (bus.route[i] == bus.route[j])) begin
                    bus.collision_error = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic dest_t mkd(input int a0, input int a1, input int a2, input int a3);
        dest_t r;
        r[0] = a0[1:0];
        r[1] = a1[1:0];
        r[2] = a2[1:0];
        r[3] = a3[1:0];
        return r;
    endfunction

    // Shedding from the tail leaves the longest collision-free prefix in priority order.
    task automatic model_round(input logic [N-1:0] v, input dest_t d, input int rr,
                               output logic [N-1:0] oe, output int drops);
        bit seen[N];
        bit stop;
        int cand;
        int kept;
        oe = '0;
        stop = 1'b0;
        cand = 0;
        kept = 0;
        for (int k = 0; k < N; k++) seen[k] = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (v[idx]) begin
                cand++;
                if (!stop && seen[d[idx]]) stop = 1'b1;
                if (!stop) begin
                    seen[d[idx]] = 1'b1;
                    oe[idx] = 1'b1;
                    kept++;
                end
            end
        end
        drops = cand - kept;
    endtask

    task automatic run_round(input logic [N-1:0] v, input dest_t d, input logic [N-1:0] mask,
                             input int delay, input logic [N-1:0] exp_oe, input int exp_drop,
                             input string tag);
        int    cyc;
        dest_t rsnap;
        bus.in_valid  = v;
        bus.in_dest   = d;
        bus.cfg_ready = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bus.in_valid = v & mask;
        end while (!bus.cfg_valid && cyc < 24);
        chk({tag, " latency"}, cyc, 2 + exp_drop);
        chk({tag, " oe"}, int'(bus.output_enable), int'(exp_oe));
        chk({tag, " drop_cnt"}, int'(bus.drop_cnt), exp_drop);
        chk({tag, " busy"}, int'(bus.busy), 1);
        for (int i = 0; i < N; i++) begin
            if (exp_oe[i]) chk($sformatf("%s route%0d", tag, i), int'(bus.route[i]), int'(d[i]));
        end
        rsnap = bus.route;
        for (int j = 0; j < delay; j++) begin
            @(posedge clk); #1;
            chk({tag, " stall cfg_valid"}, int'(bus.cfg_valid), 1);
            chk({tag, " stall in_ready"}, int'(bus.in_ready), 0);
            chk({tag, " stall oe"}, int'(bus.output_enable), int'(exp_oe));
            chk({tag, " stall route"}, int'(bus.route), int'(rsnap));
        end
        bus.cfg_ready = 1'b1;
        @(posedge clk); #1;
        bus.cfg_ready = 1'b0;
        bus.in_valid  = '0;
        chk({tag, " in_ready"}, int'(bus.in_ready), int'(exp_oe & v & mask));
        chk({tag, " cfg_valid low"}, int'(bus.cfg_valid), 0);
        chk({tag, " oe cleared"}, int'(bus.output_enable), 0);
        chk({tag, " idle"}, int'(bus.busy), 0);
        chk({tag, " drop hold"}, int'(bus.drop_cnt), exp_drop);
        @(posedge clk); #1;
        chk({tag, " ready pulse"}, int'(bus.in_ready), 0);
        m_rr = (m_rr + 1) % N;
    endtask

    initial begin
        logic [N-1:0] p_v;
        dest_t        p_d;
        logic [N-1:0] e_oe;
        int           e_drop;

        checks = 0;
        failures = 0;
        m_rr = 0;

        // Hand-computed rounds; priority pointer advances by one per round from 0.
        tbl[0] = '{4'b0011, mkd(2, 2, 0, 0), 0, 4'b0001, 1};
        tbl[1] = '{4'b0010, mkd(0, 2, 0, 0), 0, 4'b0010, 0};
        tbl[2] = '{4'b1111, mkd(1, 2, 3, 0), 3, 4'b1111, 0};
        tbl[3] = '{4'b1001, mkd(0, 0, 0, 0), 0, 4'b1000, 1};
        tbl[4] = '{4'b0001, mkd(0, 0, 0, 0), 0, 4'b0001, 0};
        tbl[5] = '{4'b1111, mkd(3, 3, 3, 3), 0, 4'b0010, 3};
        tbl[6] = '{4'b1101, mkd(1, 0, 1, 2), 0, 4'b1100, 1};

        rst = 1'b1;
        bus.cfg_ready = 1'b0;
        bus.in_valid = '0;
        bus.in_dest = '0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid  = 4'($urandom);
            bus.in_dest   = 8'($urandom);
            bus.cfg_ready = 1'($urandom);
            @(posedge clk); #1;
            chk("reset oe", int'(bus.output_enable), 0);
            chk("reset route", int'(bus.route), 0);
            chk("reset in_ready", int'(bus.in_ready), 0);
            chk("reset cfg_valid", int'(bus.cfg_valid), 0);
            chk("reset busy", int'(bus.busy), 0);
            chk("reset drop_cnt", int'(bus.drop_cnt), 0);
        end
        rst = 1'b0;
        bus.in_valid = '0;
        bus.cfg_ready = 1'b0;
        @(posedge clk); #1;
        chk("idle hold busy", int'(bus.busy), 0);
        chk("idle hold oe", int'(bus.output_enable), 0);

        for (int t = 0; t < 7; t++) begin
            run_round(tbl[t].v, tbl[t].d, 4'b1111, tbl[t].delay, tbl[t].exp_oe,
                      tbl[t].exp_drop, $sformatf("vec%0d", t));
        end

        // Reset while EVAL has a collision pending; held requests are taken again.
        bus.in_valid = 4'b0011;
        bus.in_dest  = mkd(2, 2, 0, 0);
        @(posedge clk); #1;
        chk("rstmid oe", int'(bus.output_enable), 3);
        chk("rstmid collision", int'(bus.collision_error), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_rr = 0;
        chk("rstmid busy", int'(bus.busy), 0);
        chk("rstmid oe clr", int'(bus.output_enable), 0);
        chk("rstmid route clr", int'(bus.route), 0);
        chk("rstmid drop clr", int'(bus.drop_cnt), 0);
        chk("rstmid cfg_valid", int'(bus.cfg_valid), 0);
        run_round(4'b0011, mkd(2, 2, 0, 0), 4'b1111, 0, 4'b0001, 1, "recap");

        // Input 2 withdraws mid-round: set still proposed, its grant suppressed.
        run_round(4'b0110, mkd(0, 0, 1, 0), 4'b1011, 1, 4'b0110, 0, "withdraw");

        p_v = '0;
        p_d = '0;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_v[i] && ($urandom_range(0, 1) == 1)) begin
                    p_v[i] = 1'b1;
                    p_d[i] = 2'($urandom_range(0, N - 1));
                end
            end
            if (p_v == '0) begin
                p_v[0] = 1'b1;
                p_d[0] = 2'($urandom_range(0, N - 1));
            end
            model_round(p_v, p_d, m_rr, e_oe, e_drop);
            run_round(p_v, p_d, 4'b1111, $urandom_range(0, 3), e_oe, e_drop,
                      $sformatf("rnd%0d", r));
            p_v = p_v & ~e_oe;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
